// File: rtl/avalon_pkg.sv
// Shared widths, limits and state encoding
// for the Avalon-MM RAM slave.
package avalon_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    INIT,
    READY
  } state_t;

endpackage

// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with byte
// write enables and a registered output.
module ram_sp_be
  import avalon_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [BE_W-1:0]   we,
  input  logic [DATA_W-1:0] wData,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] mem [WORDS];

  // Read-first; reads and writes never
  // share a cycle, so ordering is moot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wData[8*i +: 8];
      end
    end
    rData <= mem[addr];
  end

endmodule

// File: rtl/avalon_ram_slave.sv
// Pipelined Avalon-MM RAM slave; define
// AVALON_RAM_CLEAR_EN for post-reset zeroing.
module avalon_ram_slave
  import avalon_pkg::*;
#(
  parameter int SIZE = 16*1024,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [31:0]       s0_address,
  input  logic [BE_W-1:0]   s0_byteEnable,
  input  logic              s0_read,
  output logic [DATA_W-1:0] s0_readData,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writeData,
  output logic              s0_waitRequest,
  output logic              s0_readDataValid
);

  localparam int WORDS = SIZE / 4;
  localparam int AW = $clog2(WORDS);

  logic [AW-1:0]     wordAddr;
  logic              wrAcc;
  logic              rdAcc;
  logic [AW-1:0]     ramAddr;
  logic [BE_W-1:0]   ramWe;
  logic [DATA_W-1:0] ramWData;
  logic [DATA_W-1:0] ramQ;
  logic [READ_LATENCY-1:0] vld;
  logic              unusedAddr;

  assign wordAddr = s0_address[AW+1:2];
  assign unusedAddr = ^{s0_address[31:AW+2],
                        s0_address[1:0]};

  // A write wins over a simultaneous read.
  assign wrAcc = s0_write & ~s0_waitRequest;
  assign rdAcc = s0_read & ~s0_write
               & ~s0_waitRequest;

`ifdef AVALON_RAM_CLEAR_EN
  state_t        state;
  state_t        stateNext;
  logic [AW-1:0] clrCnt;
  logic [AW-1:0] clrCntNext;

  always_ff @(posedge clk) begin
    if (rest) begin
      state  <= INIT;
      clrCnt <= '0;
    end else begin
      state  <= stateNext;
      clrCnt <= clrCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    unique case (state)
      INIT: begin
        clrCntNext = clrCnt + 1'b1;
        if (clrCnt == AW'(WORDS - 1)) begin
          stateNext = READY;
        end
      end
      READY: begin
        stateNext = READY;
      end
      default: begin
        stateNext = INIT;
      end
    endcase
  end

  assign s0_waitRequest = (state == INIT);
`else
  assign s0_waitRequest = 1'b0;
`endif

  always_comb begin
    ramAddr  = wordAddr;
    ramWe    = wrAcc ? s0_byteEnable : '0;
    ramWData = s0_writeData;
`ifdef AVALON_RAM_CLEAR_EN
    if (state == INIT) begin
      ramAddr  = clrCnt;
      ramWe    = '1;
      ramWData = '0;
    end
`endif
  end

  ram_sp_be #(
    .WORDS(WORDS),
    .AW   (AW)
  ) uRam (
    .clk  (clk),
    .addr (ramAddr),
    .we   (ramWe),
    .wData(ramWData),
    .rData(ramQ)
  );

  always_ff @(posedge clk) begin
    if (rest) begin
      vld <= '0;
    end else begin
      vld[0] <= rdAcc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign s0_readDataValid = vld[READ_LATENCY-1];

  generate
    if (READ_LATENCY == 1) begin : gDirect
      // RAM register has no reset; mask it.
      assign s0_readData =
        vld[0] ? ramQ : '0;
    end else begin : gPipe
      logic [DATA_W-1:0] pipe [READ_LATENCY-1];

      always_ff @(posedge clk) begin
        if (rest) begin
          for (int i = 0; i < READ_LATENCY-1; i++) begin
            pipe[i] <= '0;
          end
        end else begin
          pipe[0] <= ramQ;
          for (int i = 1; i < READ_LATENCY-1; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign s0_readData = pipe[READ_LATENCY-2];
    end
  endgenerate

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed plus random bench for avalon_ram_slave
// against a word-array / response-queue model.
module tb_avalon_ram_slave;

  localparam int SIZE = 1024;
  localparam int RL = 2;
  localparam int WORDS = SIZE / 4;
  localparam int AW = $clog2(WORDS);
`ifdef AVALON_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic [31:0] s0_address = '0;
  logic [3:0]  s0_byteEnable = '0;
  logic        s0_read = 1'b0;
  logic [31:0] s0_readData;
  logic        s0_write = 1'b0;
  logic [31:0] s0_writeData = '0;
  logic        s0_waitRequest;
  logic        s0_readDataValid;

  always #5 clk = ~clk;

  avalon_ram_slave #(
    .SIZE(SIZE),
    .READ_LATENCY(RL)
  ) dut (
    .clk             (clk),
    .rest            (rest),
    .s0_address      (s0_address),
    .s0_byteEnable   (s0_byteEnable),
    .s0_read         (s0_read),
    .s0_readData     (s0_readData),
    .s0_write        (s0_write),
    .s0_writeData    (s0_writeData),
    .s0_waitRequest  (s0_waitRequest),
    .s0_readDataValid(s0_readDataValid)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] mem [WORDS];
  rsp_t        q[$];
  int          nCmp = 0;
  int          nErr = 0;
  int          cyc = 0;
  int          initLeft = 0;
  bit          armed = 1'b0;

  task automatic step(input logic rd, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] be,
                      input logic rst);
    logic acc;
    logic expV;
    int   w;
    rsp_t r;
    s0_read = rd;
    s0_write = wr;
    s0_address = a;
    s0_writeData = d;
    s0_byteEnable = be;
    rest = rst;
    if (armed) begin
      nCmp++;
      assert (s0_waitRequest === (initLeft > 0)) else begin
        nErr++;
        $error("FAIL waitReq cyc=%0d got %b exp %b",
               cyc, s0_waitRequest, initLeft > 0);
      end
    end
    acc = (initLeft == 0);
    @(posedge clk);
    cyc++;
    w = int'(a[AW+1:2]);
    if (rst) begin
      q.delete();
      initLeft = CLR ? WORDS : 0;
    end else if (initLeft > 0) begin
      mem[WORDS - initLeft] = '0;
      initLeft--;
    end else if (acc && wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[w][8*i +: 8] = d[8*i +: 8];
    end else if (acc && rd) begin
      r.due = cyc + RL - 1;
      r.data = mem[w];
      q.push_back(r);
    end
    #1;
    armed = 1'b1;
    expV = (q.size() > 0) && (q[0].due == cyc);
    nCmp++;
    assert (s0_readDataValid === expV) else begin
      nErr++;
      $error("FAIL rdValid cyc=%0d got %b exp %b",
             cyc, s0_readDataValid, expV);
    end
    if (expV) begin
      if (!$isunknown(q[0].data)) begin
        nCmp++;
        assert (s0_readData === q[0].data) else begin
          nErr++;
          $error("FAIL rdData cyc=%0d got %h exp %h",
                 cyc, s0_readData, q[0].data);
        end
      end
      void'(q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Keep a command on the bus until the model accepts it.
  task automatic hold(input logic rd, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] be);
    bit done;
    int n;
    n = 0;
    do begin
      done = (initLeft == 0);
      step(rd, wr, a, d, be, 0);
      n++;
    end while (!done && n < 2000);
    if (!done) begin
      nErr++;
      $error("FAIL holdTimeout cyc=%0d got %0d exp 0",
             cyc, initLeft);
    end
  endtask

  task automatic chkZeroData(input string tag);
    nCmp++;
    assert (s0_readData === 32'h0) else begin
      nErr++;
      $error("FAIL %s got %h exp 00000000",
             tag, s0_readData);
    end
  endtask

  initial begin
    logic [31:0] a;
    int op;
    for (int i = 0; i < WORDS; i++) mem[i] = 'x;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chkZeroData("resetData");

`ifdef AVALON_RAM_CLEAR_EN
    idle(8);
    step(0, 0, 0, 0, 0, 1);
    hold(1, 0, 32'h3F0, 0, 0);
    idle(RL);
`endif

    hold(0, 1, 32'h100, 32'h11223344, 4'hF);
    step(1, 0, 32'h100, 0, 0, 0);
    idle(RL + 1);

    step(0, 1, 32'h104, 32'h0, 4'hF, 0);
    step(0, 1, 32'h104, 32'hAABBCCDD, 4'b0101, 0);
    step(0, 1, 32'h108, 32'hFFFFFFFF, 4'h0, 0);
    step(1, 0, 32'h104, 0, 0, 0);
    idle(RL + 1);

    for (int i = 0; i < 4; i++)
      step(0, 1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 32'(4 * i), 0, 0, 0);
    idle(RL + 1);

    step(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    step(1, 0, 32'h10, 0, 0, 0);
    step(1, 0, 32'(SIZE + 16), 0, 0, 0);
    idle(RL + 1);

    step(1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chkZeroData("midResetData");
    idle(RL + 2);
    hold(1, 1, 32'h20, 32'h5, 4'hF);
    idle(RL + 1);
    step(1, 0, 32'h20, 0, 0, 0);
    idle(RL + 1);

    for (int i = 64; i < 128; i++)
      step(0, 1, 32'(4 * i), $urandom(), 4'hF, 0);
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      a[AW+1:2] = AW'(64 + $urandom_range(0, 63));
      op = $urandom_range(0, 3);
      step(op[0], op[1], a, $urandom(),
           4'($urandom_range(0, 15)), 0);
    end
    idle(RL + 2);

    nCmp++;
    assert (q.size() == 0) else begin
      nErr++;
      $error("FAIL drain got %0d exp 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/avalon_ram_slave.md
# avalon_ram_slave

Pipelined Avalon-MM slave memory that sits directly downstream of the cache's m0 master port and serves its line fills and write-backs. Accepts one read or write per cycle into a single-port, byte-enabled synchronous RAM and returns read data a fixed number of cycles later with `s0_readDataValid`. An optional post-reset clear sequence zeroes the memory before the first access is accepted.

## Interface
- `SIZE`, 16*1024: memory size in bytes; power of two, ≥ 64; `SIZE/4` 32-bit words.
- `READ_LATENCY`, 2: cycles from read acceptance to `s0_readDataValid`; legal range 1–4.
- `clk`  in  1  clock; all logic on rising edge.
- `rest`  in  1  reset, synchronous, active-high.
- `s0_address`  in  32  byte address; bits [1:0] ignored; bits above log2(SIZE)-1 ignored (address wraps).
- `s0_byteEnable`  in  4  write byte lanes; bit i enables `s0_writeData[8i+7:8i]`; ignored on reads.
- `s0_read`  in  1  read request.
- `s0_readData`  out  32  read data, meaningful only while `s0_readDataValid` is high.
- `s0_write`  in  1  write request.
- `s0_writeData`  in  32  write data.
- `s0_waitRequest`  out  1  high: command not accepted this cycle; master holds it.
- `s0_readDataValid`  out  1  one-cycle strobe per accepted read, in order.

## Operation
- States: `INIT` (clear sequence, only with the macro) and `READY`.
- Command accepted on a rising edge where (`s0_read` or `s0_write`) and `s0_waitRequest` == 0.
- Write: lanes with `s0_byteEnable[i]`=1 updated; others unchanged; `s0_byteEnable`=0 accepted, no change.
- Read: word index `s0_address[log2(SIZE)-1:2]`; returns all 4 bytes.
- `s0_read` and `s0_write` both high: write performed, read dropped, no `s0_readDataValid` for it.
- Read-during-write same cycle impossible (one command per cycle). Read accepted the cycle after a write to the same word returns the new data.
- Up to `READ_LATENCY` reads in flight; no back-pressure in `READY`; `s0_waitRequest` is 0 throughout `READY`.
- Valid tracking: `READ_LATENCY`-bit shift register; bit 0 loaded with "read accepted", output = last bit.
- Data path: RAM output register plus `READ_LATENCY`-1 pipeline registers.

## Timing
- Reset values: `s0_waitRequest` = 1 with macro, 0 without; `s0_readDataValid` = 0; `s0_readData` = 0; valid shift register cleared.
- Read accepted at edge T → `s0_readDataValid`=1 and data valid during cycle after edge T+`READ_LATENCY`-1 (i.e. sampled by master at edge T+`READ_LATENCY`).
- Back-to-back reads every cycle → back-to-back valid strobes, same order, no gaps.
- Write accepted at edge T → RAM updated at edge T; no response strobe.
- `rest` mid-operation: in-flight reads discarded, no strobes for them after reset; RAM contents untouched by reset itself (except clear sequence when enabled).
- `INIT`: counter from word 0 to `SIZE/4`-1, one zero-write per cycle, all lanes; `s0_waitRequest`=1 throughout; transitions to `READY` after the last word, `s0_waitRequest` falls the following cycle. Reset during `INIT` restarts from word 0.
- Commands presented during `INIT` are held by the master, not dropped.

## Configuration
- `AVALON_RAM_CLEAR_EN` defined: reset enters `INIT`, memory zeroed in `SIZE/4` cycles before first acceptance.
- Not defined: no `INIT` state or counter; reset goes straight to `READY`; initial contents undefined; `s0_waitRequest` tied 0.

## Structure
- Shared package `avalon_pkg`: data width 32, byte-enable width 4, state enum `{INIT, READY}`, maximum `READ_LATENCY` constant (4).
- One sub-module: `ram_sp_be` — single-port synchronous RAM, word-addressed, 4 byte-write enables, registered output, no reset; infers block RAM.
- Top level holds FSM, clear counter, valid shift register, read-data pipeline.

## Test plan
- Write 0x11223344 to 0x100 with BE=4'hF, read 0x100 → strobe exactly `READ_LATENCY` edges later, data 0x11223344.
- Write 0xAABBCCDD to 0x104 with BE=4'b0101 over 0x00000000 → read returns 0x00BB00DD.
- Reads of 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles → 4 consecutive strobes, data in address order.
- Write 0xDEADBEEF to 0x10, read 0x10 next cycle → 0xDEADBEEF; read `SIZE`+0x10 → same word (wrap).
- With `AVALON_RAM_CLEAR_EN`, SIZE=64: `s0_waitRequest` high 16 cycles after reset release; read of any word then returns 0; reset asserted at clear cycle 8 → full 16-cycle sequence restarts.
- Issue 2 reads, assert `rest` one cycle later → no `s0_readDataValid` after reset; `s0_read` and `s0_write` together to 0x20 with 0x5 → no strobe, later read returns 0x5.
